// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave datapaths.
// Holds the egress FSM state type, the byte width and the default fill byte
// sent when the transmit buffer is empty at a byte boundary.
package spi_pkg;

   localparam int SPI_BYTE_BITS = 8;
   localparam logic [SPI_BYTE_BITS-1:0] SPI_DEFAULT_IDLE_BYTE = 8'h00;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_egress_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk     system clock
//   res     synchronous active-high reset (chain preset to RESET_VAL)
//   async_i asynchronous input pin
//   level_o synchronized level
//   rise_o  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
)(
   input  logic clk,
   input  logic res,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (res) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  level_o & ~prev_q;
   assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/spi_slave_axis_egress.sv
// SPI slave transmit path: bytes taken from an AXI-Stream slave port are
// shifted out on MISO. spi_clk/spi_csn are oversampled in the clk domain;
// MISO is updated after each synchronized spi_clk rising edge, so the master
// samples it on the falling edge.
// Ports:
//   clk, res                 system clock, synchronous active-high reset
//   spi_clk, spi_csn         asynchronous SPI clock / chip select (low active)
//   spi_miso, spi_miso_oe    serial data out and its output enable
//   s_axis_tdata/tvalid/tready  byte input stream
//   err_underrun             sticky: byte boundary hit with no data buffered
//   busy                     transaction in progress
// Build option: SPI_SLAVE_EGRESS_PREFETCH_EN turns the single holding
// register into a 2-entry FIFO so the host can stay one byte ahead.
module spi_slave_axis_egress
   import spi_pkg::*;
#(
   parameter bit                       MSB_FIRST   = 1'b1,
   parameter logic [SPI_BYTE_BITS-1:0] IDLE_BYTE   = SPI_DEFAULT_IDLE_BYTE,
   parameter int                       SYNC_STAGES = 2
)(
   input  logic                     clk,
   input  logic                     res,
   input  logic                     spi_clk,
   input  logic                     spi_csn,
   output logic                     spi_miso,
   output logic                     spi_miso_oe,
   input  logic [SPI_BYTE_BITS-1:0] s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic                     err_underrun,
   output logic                     busy
);

   localparam int CNT_W = $clog2(SPI_BYTE_BITS);

   logic clk_lvl, clk_rise, clk_fall;
   logic csn_lvl, csn_rise, csn_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
      .clk(clk), .res(res), .async_i(spi_clk),
      .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
      .clk(clk), .res(res), .async_i(spi_csn),
      .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{clk_lvl, clk_fall, csn_lvl};

   // ---------------- transmit buffer ----------------
   logic                     push, pop, avail;
   logic [SPI_BYTE_BITS-1:0] head;

`ifdef SPI_SLAVE_EGRESS_PREFETCH_EN
   logic [1:0][SPI_BYTE_BITS-1:0] mem_q, mem_d;
   logic                          rd_ptr_q, rd_ptr_d;
   logic [1:0]                    cnt_q, cnt_d;
   logic                          wr_ptr;

   assign s_axis_tready = (cnt_q < 2'd2) && !res;
   assign avail         = (cnt_q != 2'd0);
   assign head          = mem_q[rd_ptr_q];
   // Write slot follows the head by the occupancy (only 0 or 1 when pushing).
   assign wr_ptr        = rd_ptr_q ^ cnt_q[0];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) mem_d[wr_ptr] = s_axis_tdata;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
`else
   logic                     hold_valid_q, hold_valid_d;
   logic [SPI_BYTE_BITS-1:0] hold_data_q, hold_data_d;

   assign s_axis_tready = !hold_valid_q && !res;
   assign avail         = hold_valid_q;
   assign head          = hold_data_q;

   // push and pop are exclusive: pop needs a full buffer, push an empty one.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (push) begin
         hold_valid_d = 1'b1;
         hold_data_d  = s_axis_tdata;
      end
      if (pop) hold_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end
`endif

   assign push = s_axis_tvalid && s_axis_tready;

   // ---------------- shift FSM ----------------
   spi_egress_state_t        state_q, state_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [SPI_BYTE_BITS-1:0] shift_q, shift_d, byte_nxt;
   logic                     miso_q, miso_d;
   logic                     oe_q, oe_d;
   logic                     busy_q, busy_d;
   logic                     err_q, err_d;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      busy_d    = busy_q;
      err_d     = err_q;
      pop       = 1'b0;
      byte_nxt  = shift_q;
      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               oe_d      = 1'b1;
               busy_d    = 1'b1;
               err_d     = 1'b0;
            end
         end
         SHIFT: begin
            // CS release wins over a coincident clock edge; a partial byte
            // is dropped, never re-sent.
            if (csn_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               miso_d    = 1'b0;
               oe_d      = 1'b0;
               busy_d    = 1'b0;
            end else if (clk_rise) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == '0) begin
                  if (avail) begin
                     byte_nxt = head;
                     pop      = 1'b1;
                  end else begin
                     byte_nxt = IDLE_BYTE;
                     err_d    = 1'b1;
                  end
               end else if (MSB_FIRST) begin
                  byte_nxt = {shift_q[SPI_BYTE_BITS-2:0], 1'b0};
               end else begin
                  byte_nxt = {1'b0, shift_q[SPI_BYTE_BITS-1:1]};
               end
               shift_d = byte_nxt;
               miso_d  = MSB_FIRST ? byte_nxt[SPI_BYTE_BITS-1] : byte_nxt[0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign spi_miso     = miso_q;
   assign spi_miso_oe  = oe_q;
   assign busy         = busy_q;
   assign err_underrun = err_q;

endmodule

// File: tb/tb_spi_slave_axis_egress.sv
// Bench for spi_slave_axis_egress: an MSB-first and an LSB-first instance
// share one SPI master and one AXIS source. The reference model is a queue
// of accepted bytes per instance; every started byte slot consumes the head
// (or the fill byte when empty, which also flags an underrun).
module tb_spi_slave_axis_egress;

   localparam int         SS    = 2;
   localparam logic [7:0] IDLE0 = 8'h00;
   localparam logic [7:0] IDLE1 = 8'h5A;

   logic       clk = 1'b0;
   logic       res, spi_clk, spi_csn, tvalid;
   logic [7:0] tdata;
   logic       miso0, oe0, tready0, err0, busy0;
   logic       miso1, oe1, tready1, err1, busy1;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] tx_q[$];
   logic [7:0] m0[$];
   logic [7:0] m1[$];

   always #5 clk = ~clk;

   spi_slave_axis_egress #(.MSB_FIRST(1'b1), .IDLE_BYTE(IDLE0), .SYNC_STAGES(SS)) dut0 (
      .clk(clk), .res(res), .spi_clk(spi_clk), .spi_csn(spi_csn),
      .spi_miso(miso0), .spi_miso_oe(oe0),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready0),
      .err_underrun(err0), .busy(busy0)
   );

   spi_slave_axis_egress #(.MSB_FIRST(1'b0), .IDLE_BYTE(IDLE1), .SYNC_STAGES(SS)) dut1 (
      .clk(clk), .res(res), .spi_clk(spi_clk), .spi_csn(spi_csn),
      .spi_miso(miso1), .spi_miso_oe(oe1),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready1),
      .err_underrun(err1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // AXIS source: offers tx_q in order; records handshakes seen by each DUT.
   initial begin : feeder
      logic hs0, hs1;
      tvalid = 1'b0;
      tdata  = 8'h00;
      forever begin
         @(negedge clk);
         hs0 = tvalid && tready0;
         hs1 = tvalid && tready1;
         @(posedge clk);
         if (hs0) m0.push_back(tdata);
         if (hs1) m1.push_back(tdata);
         if (hs0 && tx_q.size() > 0) void'(tx_q.pop_front());
         #1;
         tvalid = (tx_q.size() > 0);
         if (tvalid) tdata = tx_q[0];
      end
   end

   task automatic spi_bit(output logic b0, output logic b1);
      spi_clk = 1'b1;
      cyc($urandom_range(SS + 2, SS + 5));
      b0 = miso0;
      b1 = miso1;
      spi_clk = 1'b0;
      cyc($urandom_range(SS + 2, SS + 5));
   endtask

   task automatic run_xfer(input int nbits);
      logic       r0[$];
      logic       r1[$];
      logic       b0, b1;
      logic       ur0, ur1;
      logic [7:0] e0, e1, g0, g1, mk0, mk1;
      int         nb;
      ur0 = 1'b0;
      ur1 = 1'b0;
      spi_csn = 1'b0;
      cyc(8);
      chk("start_oe",   {oe1, oe0},     2'b11);
      chk("start_busy", {busy1, busy0}, 2'b11);
      chk("start_err",  {err1, err0},   2'b00);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(b0, b1);
         r0.push_back(b0);
         r1.push_back(b1);
      end
      spi_csn = 1'b1;
      tx_q.delete();
      tvalid = 1'b0;
      cyc(SS);
      chk("oe_latency", {oe1, oe0}, 2'b11);
      cyc(1);
      chk("end_oe",   {oe1, oe0},     2'b00);
      chk("end_busy", {busy1, busy0}, 2'b00);
      chk("end_miso", {miso1, miso0}, 2'b00);
      for (int k = 0; k * 8 < nbits; k++) begin
         if (m0.size() > 0) e0 = m0.pop_front();
         else begin e0 = IDLE0; ur0 = 1'b1; end
         if (m1.size() > 0) e1 = m1.pop_front();
         else begin e1 = IDLE1; ur1 = 1'b1; end
         nb = (nbits - 8 * k < 8) ? nbits - 8 * k : 8;
         g0 = 8'h00;
         g1 = 8'h00;
         for (int j = 0; j < nb; j++) begin
            g0[7 - j] = r0[8 * k + j];
            g1[j]     = r1[8 * k + j];
         end
         mk0 = 8'hFF << (8 - nb);
         mk1 = 8'hFF >> (8 - nb);
         chk($sformatf("msb_byte%0d", k), {24'h0, g0}, {24'h0, e0 & mk0});
         chk($sformatf("lsb_byte%0d", k), {24'h0, g1}, {24'h0, e1 & mk1});
      end
      chk("err_msb", err0, ur0);
      chk("err_lsb", err1, ur1);
   endtask

   initial begin : watchdog
      #5_000_000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic b0, b1;
      res     = 1'b1;
      spi_clk = 1'b0;
      spi_csn = 1'b1;
      cyc(3);
      chk("rst_miso",   {miso1, miso0},     2'b00);
      chk("rst_oe",     {oe1, oe0},         2'b00);
      chk("rst_tready", {tready1, tready0}, 2'b00);
      chk("rst_err",    {err1, err0},       2'b00);
      chk("rst_busy",   {busy1, busy0},     2'b00);
      res = 1'b0;
      cyc(1);
      chk("tready_idle", {tready1, tready0}, 2'b11);

      // single pre-loaded byte
      tx_q.push_back(8'hA5);
      cyc(3);
      chk("preload_full", {tready1, tready0}, 2'b00);
      run_xfer(8);

      // back-to-back bytes
      tx_q.push_back(8'h3C);
      tx_q.push_back(8'hC3);
      run_xfer(16);

      // underrun, then the next transaction starts with the flag cleared
      run_xfer(8);
      chk("underrun_sticky", {err1, err0}, 2'b11);

      // mid-byte abort; the byte queued behind it survives
      tx_q.push_back(8'hFF);
      tx_q.push_back(8'h81);
      run_xfer(3);
      run_xfer(8);

      // reset in the middle of bit 4
      tx_q.push_back(8'h77);
      tx_q.push_back(8'h12);
      cyc(3);
      spi_csn = 1'b0;
      cyc(8);
      for (int i = 0; i < 3; i++) spi_bit(b0, b1);
      spi_clk = 1'b1;
      cyc(5);
      res = 1'b1;
      cyc(1);
      chk("mid_rst_miso",   {miso1, miso0},     2'b00);
      chk("mid_rst_oe",     {oe1, oe0},         2'b00);
      chk("mid_rst_busy",   {busy1, busy0},     2'b00);
      chk("mid_rst_tready", {tready1, tready0}, 2'b00);
      spi_csn = 1'b1;
      spi_clk = 1'b0;
      tx_q.delete();
      tvalid = 1'b0;
      cyc(4);
      m0.delete();
      m1.delete();
      res = 1'b0;
      cyc(1);
      chk("post_rst_tready", {tready1, tready0}, 2'b11);
      chk("post_rst_err",    {err1, err0},       2'b00);
      run_xfer(8);

      // randomized transactions, with stray spi_clk toggles while CS is high
      for (int t = 0; t < 25; t++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom()));
         if ($urandom_range(0, 2) == 0) begin
            for (int i = 0; i < 2; i++) begin
               spi_clk = 1'b1;
               cyc(5);
               spi_clk = 1'b0;
               cyc(5);
            end
         end
         run_xfer($urandom_range(1, 30));
      end

      cyc(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
